// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three 2-deep source queues (ALU, LSB, BRU) merged
// round-robin onto one registered broadcast port toward ROB/RS/LSB.
module cdb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic        alu_valid,
    input  logic [3:0]  alu_rob_id,
    input  logic [31:0] alu_value,
    output logic        alu_ready,
    input  logic        lsb_valid,
    input  logic [3:0]  lsb_rob_id,
    input  logic [31:0] lsb_value,
    output logic        lsb_ready,
    input  logic        bru_valid,
    input  logic [3:0]  bru_rob_id,
    input  logic [31:0] bru_value,
    input  logic        bru_jump,
    input  logic [31:0] bru_target,
    output logic        bru_ready,
    output logic        cdb_valid,
    output logic [3:0]  cdb_rob_id,
    output logic [31:0] cdb_value,
    output logic        cdb_jump,
    output logic [31:0] cdb_target,
    output logic [1:0]  cdb_src
);

    localparam int         NSRC    = 3;
    localparam logic [1:0] SRC_BRU = 2'd2;

    typedef struct packed {
        logic [3:0]  rob_id;
        logic [31:0] value;
        logic        jump;
        logic [31:0] target;
    } entry_t;

    entry_t          mem_q [NSRC][2];
    entry_t          mem_d [NSRC][2];
    logic [NSRC-1:0] wr_ptr_q, wr_ptr_d;
    logic [NSRC-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]      count_q [NSRC];
    logic [1:0]      count_d [NSRC];
    logic [1:0]      last_grant_q, last_grant_d;
    entry_t          cdb_q, cdb_d;
    logic            cdb_valid_q, cdb_valid_d;
    logic [1:0]      cdb_src_q, cdb_src_d;

    logic [NSRC-1:0] in_valid;
    entry_t          in_data [NSRC];
    logic [NSRC-1:0] can_enq;
    logic [NSRC-1:0] not_empty;
    logic [NSRC-1:0] enq;
    logic [NSRC-1:0] deq;
    logic            gnt_vld;
    logic [1:0]      gnt_src;
    logic [1:0]      cand;

    function automatic logic [1:0] next_src(input logic [1:0] s);
        return (s == SRC_BRU) ? 2'd0 : s + 2'd1;
    endfunction

    always_comb begin
        in_valid   = {bru_valid, lsb_valid, alu_valid};
        in_data[0] = '{rob_id: alu_rob_id, value: alu_value, jump: 1'b0, target: 32'd0};
        in_data[1] = '{rob_id: lsb_rob_id, value: lsb_value, jump: 1'b0, target: 32'd0};
        in_data[2] = '{rob_id: bru_rob_id, value: bru_value, jump: bru_jump, target: bru_target};
    end

    // Ready comes from registered occupancy only, so a full queue stays
    // not-ready even in the cycle its head is being granted.
    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            can_enq[s]   = (count_q[s] < 2'd2);
            not_empty[s] = (count_q[s] != 2'd0);
        end
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_src = 2'd0;
        cand    = next_src(last_grant_q);
        for (int k = 0; k < NSRC; k++) begin
            if (!gnt_vld && not_empty[cand]) begin
                gnt_vld = 1'b1;
                gnt_src = cand;
            end
            cand = next_src(cand);
        end
    end

    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            enq[s] = rdy && !rollback && in_valid[s] && can_enq[s];
            deq[s] = rdy && !rollback && gnt_vld && (gnt_src == 2'(s));
        end
    end

    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        cdb_d        = cdb_q;
        cdb_valid_d  = cdb_valid_q;
        cdb_src_d    = cdb_src_q;
        if (rdy) begin
            if (rollback) begin
                for (int s = 0; s < NSRC; s++) begin
                    count_d[s] = 2'd0;
                end
                wr_ptr_d     = '0;
                rd_ptr_d     = '0;
                cdb_valid_d  = 1'b0;
                last_grant_d = SRC_BRU;
            end else begin
                cdb_valid_d = gnt_vld;
                if (gnt_vld) begin
                    cdb_d        = mem_q[gnt_src][rd_ptr_q[gnt_src]];
                    cdb_src_d    = gnt_src;
                    last_grant_d = gnt_src;
                end
                for (int s = 0; s < NSRC; s++) begin
                    if (enq[s]) begin
                        mem_d[s][wr_ptr_q[s]] = in_data[s];
                        wr_ptr_d[s]           = ~wr_ptr_q[s];
                    end
                    if (deq[s]) begin
                        rd_ptr_d[s] = ~rd_ptr_q[s];
                    end
                    if (enq[s] && !deq[s]) begin
                        count_d[s] = count_q[s] + 2'd1;
                    end else if (deq[s] && !enq[s]) begin
                        count_d[s] = count_q[s] - 2'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NSRC; s++) begin
                mem_q[s][0] <= '0;
                mem_q[s][1] <= '0;
                count_q[s]  <= 2'd0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            last_grant_q <= SRC_BRU;
            cdb_q        <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_src_q    <= 2'd0;
        end else begin
            mem_q        <= mem_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            last_grant_q <= last_grant_d;
            cdb_q        <= cdb_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_src_q    <= cdb_src_d;
        end
    end

    assign alu_ready  = can_enq[0];
    assign lsb_ready  = can_enq[1];
    assign bru_ready  = can_enq[2];
    assign cdb_valid  = cdb_valid_q;
    assign cdb_rob_id = cdb_q.rob_id;
    assign cdb_value  = cdb_q.value;
    assign cdb_jump   = cdb_q.jump;
    assign cdb_target = cdb_q.target;
    assign cdb_src    = cdb_src_q;

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-low; ports listed clock and reset first.
REQ-002 SHALL expose: clk  in  1  rising-edge clock.
REQ-003 SHALL expose: rst  in  1  asynchronous active-low reset (0 = reset).
REQ-004 SHALL expose: rdy  in  1  global clock enable; low = all state frozen.
REQ-005 SHALL expose: rollback  in  1  flush request from ROB, sampled on clk.
REQ-006 SHALL expose: alu_valid  in  1;  alu_rob_id  in  4;  alu_value  in  32  ALU result.
REQ-007 SHALL expose: alu_ready  out  1  ALU queue can accept.
REQ-008 SHALL expose: lsb_valid  in  1;  lsb_rob_id  in  4;  lsb_value  in  32  load result.
REQ-009 SHALL expose: lsb_ready  out  1  LSB queue can accept.
REQ-010 SHALL expose: bru_valid  in  1;  bru_rob_id  in  4;  bru_value  in  32 (link value);  bru_jump  in  1;  bru_target  in  32.
REQ-011 SHALL expose: bru_ready  out  1  BRU queue can accept.
REQ-012 SHALL expose: cdb_valid  out  1;  cdb_rob_id  out  4;  cdb_value  out  32;  cdb_jump  out  1;  cdb_target  out  32  registered broadcast to ROB/RS/LSB.
REQ-013 SHALL expose: cdb_src  out  2  source of current broadcast (0 ALU, 1 LSB, 2 BRU).

Function
REQ-014 SHALL keep one 2-entry FIFO per source (ALU, LSB, BRU) holding that source's payload; ALU/LSB entries store jump=0, target=0.
REQ-015 SHALL drive x_ready = 1 iff that FIFO count < 2, from registered state only (no same-cycle dequeue credit).
REQ-016 SHALL enqueue on a rising edge with rdy=1, rollback=0, x_valid=1, x_ready=1; x_valid with x_ready=0 is ignored (source holds).
REQ-017 SHALL select at most one non-empty FIFO per cycle, round-robin, search order starting at the source after last_grant (0->1->2->0).
REQ-018 SHALL dequeue the granted FIFO head and register it onto cdb_* with cdb_valid=1 at the same edge; no grant -> cdb_valid=0 next cycle, other cdb_* hold.
REQ-019 SHALL update last_grant only when a grant occurs.
REQ-020 SHALL give minimum latency 2 edges: payload accepted at edge E appears with cdb_valid=1 after edge E+1; no bypass.
REQ-021 SHALL keep cdb_valid high for exactly one cycle per grant; back-to-back grants allowed every cycle.
REQ-022 SHALL handle simultaneous enqueue and dequeue on one FIFO with count 1: count stays 1, order preserved.
REQ-023 SHALL preserve per-source FIFO order; no ordering guarantee across sources.
REQ-024 SHALL, on rollback=1 (with rdy=1), empty all FIFOs, drop that cycle's inputs, set cdb_valid=0, last_grant=2; no grant that cycle.
REQ-025 SHALL, with rdy=0, change no state: FIFOs, pointers, cdb_* hold; rollback ignored.
REQ-026 SHALL wrap FIFO pointers modulo 2; count range 0..2.

Reset
REQ-027 SHALL on rst=0, immediately: all FIFOs empty, last_grant=2, cdb_valid=0, cdb_rob_id=0, cdb_value=0, cdb_jump=0, cdb_target=0, cdb_src=0.
REQ-028 SHALL drive alu_ready=lsb_ready=bru_ready=1 during and after reset.
REQ-029 SHALL discard in-flight entries on reset mid-operation; first grant after release is ALU if ALU non-empty.

Verification
REQ-030 Single ALU: alu_valid=1, id=3, value=0x11 at edge 1 -> cdb_valid=1, id=3, value=0x11, src=0 after edge 2, cdb_valid=0 after edge 3.
REQ-031 Fairness: ALU, LSB, BRU all valid same edge (ids 1,2,3) -> broadcasts ids 1,2,3 on consecutive cycles, srcs 0,1,2.
REQ-032 Backpressure: LSB valid 3 consecutive edges with no grants possible (rdy=0 after 2 enqueues) -> lsb_ready=0 at count 2; third payload not lost, enqueued after rdy returns and slot frees.
REQ-033 Branch payload: bru id=7, value=0x104, jump=1, target=0x200 -> cdb_jump=1, cdb_target=0x200, src=2.
REQ-034 Rollback: two ALU and one BRU entries queued, rollback=1 -> next cycle cdb_valid=0, all x_ready=1, no stale ids ever broadcast.
REQ-035 Async reset mid-stream: rst=0 between edges -> cdb_valid=0 immediately, no clock edge required.
